// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file and its busy-bit scoreboard.
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ADDR_W = 3;

  // Busy_Count must represent 0..DEPTH inclusive, hence one extra bit.
  function automatic int busy_cnt_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/busy_scoreboard.sv
// Per-register busy bits, same-cycle reservation grant and a registered busy-register count.
module busy_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int ZERO_REG = 0,
  parameter int DEPTH    = 1 << ADDR_W,
  parameter int CNT_W    = busy_cnt_w(ADDR_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic              rsv_en_i,
  input  logic [ADDR_W-1:0] rsv_addr_i,
  output logic              rsv_grant_o,
  output logic [DEPTH-1:0]  busy_o,
  output logic [CNT_W-1:0]  busy_count_o
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_zero, rsv_zero, wr_hit, rsv_set, inc, dec;

  assign wr_zero  = (ZERO_REG != 0) && (wr_addr_i == '0);
  assign rsv_zero = (ZERO_REG != 0) && (rsv_addr_i == '0);
  assign wr_hit   = wr_en_i && !wr_zero;

  // A write retiring the same register frees it in time for a new reservation.
  assign rsv_grant_o = rsv_en_i &&
                       (rsv_zero || !busy_q[rsv_addr_i] ||
                        (wr_en_i && (wr_addr_i == rsv_addr_i)));
  assign rsv_set     = rsv_grant_o && !rsv_zero;

  assign inc = rsv_set && !busy_q[rsv_addr_i];
  assign dec = wr_hit && busy_q[wr_addr_i] &&
               !(rsv_set && (rsv_addr_i == wr_addr_i));

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    busy_d = busy_q;
    if (wr_hit)  busy_d[wr_addr_i]  = 1'b0;
    if (rsv_set) busy_d[rsv_addr_i] = 1'b1;
  end

  always_comb begin
    count_d = count_q;
    unique case ({inc, dec})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst_i) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_o       = busy_q;
  assign busy_count_o = count_q;

endmodule

// File: rtl/register_file_scoreboard.sv
// Architectural register file: two bypassed combinational read ports, one write port,
// optional hardwired-zero r0 and busy-bit reservation tracking.
module register_file_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           WriteEN,
  input  logic [ADDR_W-1:0]              Write_Address,
  input  logic [DATA_W-1:0]              Write_Data,
  input  logic [ADDR_W-1:0]              Read_AddressA,
  input  logic [ADDR_W-1:0]              Read_AddressB,
  output logic [DATA_W-1:0]              Read_DataA,
  output logic [DATA_W-1:0]              Read_DataB,
  output logic                           Read_ReadyA,
  output logic                           Read_ReadyB,
  input  logic                           Reserve_EN,
  input  logic [ADDR_W-1:0]              Reserve_Address,
  output logic                           Reserve_Grant,
  output logic [busy_cnt_w(ADDR_W)-1:0]  Busy_Count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = busy_cnt_w(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy;

  function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  busy_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .DEPTH    (DEPTH),
    .CNT_W    (CNT_W)
  ) u_busy (
    .clk_i        (CLK),
    .rst_i        (RST),
    .wr_en_i      (WriteEN),
    .wr_addr_i    (Write_Address),
    .rsv_en_i     (Reserve_EN),
    .rsv_addr_i   (Reserve_Address),
    .rsv_grant_o  (Reserve_Grant),
    .busy_o       (busy),
    .busy_count_o (Busy_Count)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: the array is reset because reads after reset must return 0 for every address.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (WriteEN && !is_zero(Write_Address)) begin
      mem_q[Write_Address] <= Write_Data;
    end
  end

  always_comb begin
    Read_DataA  = mem_q[Read_AddressA];
    Read_ReadyA = !busy[Read_AddressA];
    if (is_zero(Read_AddressA)) begin
      Read_DataA  = '0;
      Read_ReadyA = 1'b1;
    end else if ((BYPASS != 0) && WriteEN && (Write_Address == Read_AddressA)) begin
      Read_DataA  = Write_Data;
      Read_ReadyA = 1'b1;
    end
  end

  always_comb begin
    Read_DataB  = mem_q[Read_AddressB];
    Read_ReadyB = !busy[Read_AddressB];
    if (is_zero(Read_AddressB)) begin
      Read_DataB  = '0;
      Read_ReadyB = 1'b1;
    end else if ((BYPASS != 0) && WriteEN && (Write_Address == Read_AddressB)) begin
      Read_DataB  = Write_Data;
      Read_ReadyB = 1'b1;
    end
  end

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Scoreboard bench: two instances (ZERO_REG=0 and ZERO_REG=1) share stimulus and are
// compared against an array-based reference model.
module tb_register_file_scoreboard;

  logic       CLK = 1'b0;
  logic       RST, WriteEN, Reserve_EN;
  logic [2:0] Write_Address, Read_AddressA, Read_AddressB, Reserve_Address;
  logic [7:0] Write_Data;

  logic [7:0] rda [2];
  logic [7:0] rdb [2];
  logic       rya [2];
  logic       ryb [2];
  logic       gnt [2];
  logic [3:0] cnt [2];

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0][7:0] da;
    logic [1:0][7:0] db;
    logic [1:0]      ra;
    logic [1:0]      rb;
    logic [1:0]      g;
    logic [1:0][3:0] c;
  } exp_t;

  exp_t exp_q[$];

  logic [7:0] m_mem  [2][8];
  bit         m_busy [2][8];

  always #5 CLK = ~CLK;

  register_file_scoreboard #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) u_dut0 (
    .CLK(CLK), .RST(RST), .WriteEN(WriteEN), .Write_Address(Write_Address),
    .Write_Data(Write_Data), .Read_AddressA(Read_AddressA), .Read_AddressB(Read_AddressB),
    .Read_DataA(rda[0]), .Read_DataB(rdb[0]), .Read_ReadyA(rya[0]), .Read_ReadyB(ryb[0]),
    .Reserve_EN(Reserve_EN), .Reserve_Address(Reserve_Address),
    .Reserve_Grant(gnt[0]), .Busy_Count(cnt[0])
  );

  register_file_scoreboard #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .WriteEN(WriteEN), .Write_Address(Write_Address),
    .Write_Data(Write_Data), .Read_AddressA(Read_AddressA), .Read_AddressB(Read_AddressB),
    .Read_DataA(rda[1]), .Read_DataB(rdb[1]), .Read_ReadyA(rya[1]), .Read_ReadyB(ryb[1]),
    .Reserve_EN(Reserve_EN), .Reserve_Address(Reserve_Address),
    .Reserve_Grant(gnt[1]), .Busy_Count(cnt[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit is_r0(input int z, input logic [2:0] a);
    return (z == 1) && (a == 3'd0);
  endfunction

  // Reference read: hardwired zero, then forwarding, then stored value.
  task automatic model_read(input int z, input logic [2:0] a,
                            output logic [7:0] d, output logic r);
    if (is_r0(z, a)) begin
      d = 8'h00; r = 1'b1;
    end else if (WriteEN && Write_Address == a) begin
      d = Write_Data; r = 1'b1;
    end else begin
      d = m_mem[z][a]; r = !m_busy[z][a];
    end
  endtask

  task automatic step(input bit rst, input bit we, input logic [2:0] wa, input logic [7:0] wd,
                      input logic [2:0] a, input logic [2:0] b,
                      input bit re, input logic [2:0] rsa, input bit chk);
    exp_t e;
    bit   grant [2];
    int   n;
    RST = rst; WriteEN = we; Write_Address = wa; Write_Data = wd;
    Read_AddressA = a; Read_AddressB = b; Reserve_EN = re; Reserve_Address = rsa;
    for (int z = 0; z < 2; z++) begin
      model_read(z, a, e.da[z], e.ra[z]);
      model_read(z, b, e.db[z], e.rb[z]);
      grant[z] = re && (is_r0(z, rsa) || !m_busy[z][rsa] || (we && wa == rsa));
      e.g[z] = grant[z];
      n = 0;
      for (int i = 0; i < 8; i++) n += int'(m_busy[z][i]);
      e.c[z] = 4'(n);
    end
    if (chk) exp_q.push_back(e);
    @(posedge CLK);
    for (int z = 0; z < 2; z++) begin
      if (rst) begin
        for (int i = 0; i < 8; i++) begin
          m_mem[z][i]  = 8'h00;
          m_busy[z][i] = 1'b0;
        end
      end else begin
        if (we && !is_r0(z, wa)) begin
          m_mem[z][wa]  = wd;
          m_busy[z][wa] = 1'b0;
        end
        if (grant[z] && !is_r0(z, rsa)) m_busy[z][rsa] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle_read(input logic [2:0] a, input logic [2:0] b);
    step(0, 0, 3'd0, 8'h00, a, b, 0, 3'd0, 1);
  endtask

  // Monitor: compares every DUT output against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int z = 0; z < 2; z++) begin
          check($sformatf("z%0d rdA", z), 32'(rda[z]), 32'(e.da[z]));
          check($sformatf("z%0d rdB", z), 32'(rdb[z]), 32'(e.db[z]));
          check($sformatf("z%0d rdyA", z), 32'(rya[z]), 32'(e.ra[z]));
          check($sformatf("z%0d rdyB", z), 32'(ryb[z]), 32'(e.rb[z]));
          check($sformatf("z%0d grant", z), 32'(gnt[z]), 32'(e.g[z]));
          check($sformatf("z%0d count", z), 32'(cnt[z]), 32'(e.c[z]));
        end
      end
    end
  end

  initial begin
    for (int z = 0; z < 2; z++)
      for (int i = 0; i < 8; i++) begin
        m_mem[z][i] = 8'h00; m_busy[z][i] = 1'b0;
      end
    RST = 1'b1; WriteEN = 1'b0; Write_Address = '0; Write_Data = '0;
    Read_AddressA = '0; Read_AddressB = '0; Reserve_EN = 1'b0; Reserve_Address = '0;
    @(posedge CLK); #1;

    step(1, 0, 3'd0, 8'h00, 3'd0, 3'd1, 0, 3'd0, 0);
    step(1, 1, 3'd2, 8'h77, 3'd0, 3'd1, 1, 3'd4, 1);
    for (int i = 0; i < 8; i += 2) idle_read(3'(i), 3'(i + 1));

    step(0, 1, 3'd3, 8'hA5, 3'd0, 3'd3, 0, 3'd0, 1);
    idle_read(3'd3, 3'd1);

    step(0, 0, 3'd0, 8'h00, 3'd5, 3'd3, 1, 3'd5, 1);
    step(0, 0, 3'd0, 8'h00, 3'd5, 3'd3, 1, 3'd5, 1);
    step(0, 1, 3'd5, 8'h3C, 3'd1, 3'd3, 0, 3'd0, 1);
    idle_read(3'd5, 3'd3);

    step(0, 0, 3'd0, 8'h00, 3'd2, 3'd2, 1, 3'd2, 1);
    step(0, 1, 3'd2, 8'h11, 3'd1, 3'd4, 1, 3'd2, 1);
    idle_read(3'd2, 3'd2);

    step(0, 1, 3'd0, 8'hFF, 3'd0, 3'd0, 1, 3'd0, 1);
    idle_read(3'd0, 3'd2);

    for (int i = 0; i < 8; i++) step(0, 0, 3'd0, 8'h00, 3'(i), 3'd0, 1, 3'(i), 1);
    idle_read(3'd7, 3'd6);
    step(1, 0, 3'd0, 8'h00, 3'd1, 3'd2, 0, 3'd0, 1);
    for (int i = 0; i < 8; i += 2) idle_read(3'(i), 3'(i + 1));

    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)), 3'($urandom),
           8'($urandom), 3'($urandom), 3'($urandom),
           1'($urandom_range(0, 1)), 3'($urandom), 1);
    end

    WriteEN = 1'b0; Reserve_EN = 1'b0; RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("queue drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
